// File: rtl/lsu_bus.sv
// ============================================================================
// lsu_bus : load/store unit driving a single-outstanding req/ack data bus.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module lsu_bus #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_REQ   = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] bus_wdata_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] rd_q;
    logic        err_q;

    logic        legal;
    logic        timeout_hit;
    logic [31:0] wdata_rep;
    logic [3:0]  wstrb_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        legal = 1'b0;
        case (mem_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign timeout_hit = (cnt_q == TO_LAST);

    // Store data is replicated across lanes so the strobes alone select bytes.
    always_comb begin
        wdata_rep = wdata;
        wstrb_new = 4'b1111;
        case (mem_size)
            2'b00: begin
                wdata_rep = {4{wdata[7:0]}};
                wstrb_new = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_rep = {2{wdata[15:0]}};
                wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_rep = wdata;
                wstrb_new = 4'b1111;
            end
        endcase
        if (!mem_we) begin
            wstrb_new = 4'b0000;
        end
    end

    always_comb begin
        byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    state_d = legal ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (bus_ack || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state_q == S_REQ);
        done    = (state_q == S_DONE);
        err     = (state_q == S_DONE) && err_q;
        stall   = ((state_q == S_IDLE) && mem_req) || (state_q == S_REQ);
    end

    // Bus outputs are frozen at acceptance; an ack in the timeout cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 16'd0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wstrb_q <= 4'd0;
            bus_wdata_q <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            rd_q        <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_req) begin
                        if (legal) begin
                            cnt_q       <= 16'd0;
                            bus_we_q    <= mem_we;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_wstrb_q <= wstrb_new;
                            bus_wdata_q <= wdata_rep;
                            off_q       <= addr[1:0];
                            size_q      <= mem_size;
                            uns_q       <= mem_unsigned;
                        end else begin
                            err_q <= 1'b1;
                            rd_q  <= 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        err_q <= 1'b0;
                        rd_q  <= bus_we_q ? 32'd0 : load_val;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        rd_q  <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd        = rd_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus.sv
// ============================================================================
// tb_lsu_bus : scoreboard bench for lsu_bus with a behavioural reference model.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module tb_lsu_bus;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] rd;
    logic        stall, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    lsu_bus #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .rd(rd), .stall(stall), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          done_cyc;
    } done_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          ncyc;
    } bus_t;

    done_t dq[$];
    bus_t  bq[$];

    int          nvec = 0;
    int          nmis = 0;
    int          cyc  = 0;
    int          ack_delay = 0;
    logic [31:0] resp_rdata = 32'd0;
    logic [31:0] exp_hold = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    endtask

    // Reference model: derives the whole outcome of one access from its inputs.
    task automatic model(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdv, input int d,
                         output logic legal, output logic [31:0] rd_e,
                         output logic err_e, output logic [3:0] strb_e,
                         output logic [31:0] wd_e, output int lat, output int ncyc);
        int          nb;
        logic [31:0] mask, val;
        logic        to;
        nb    = 1 << sz;
        legal = (sz != 2'd3) && ((a % nb) == 0);
        to    = legal && (d >= T);
        mask  = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val   = (rdv >> (8 * a[1:0])) & mask;
        if (!u && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        rd_e   = (!legal || to || we) ? 32'd0 : val;
        err_e  = !legal || to;
        strb_e = we ? 4'(((1 << nb) - 1) << a[1:0]) : 4'b0000;
        for (int i = 0; i < 4; i++) wd_e[8 * i +: 8] = wd[8 * (i % nb) +: 8];
        lat  = !legal ? 1 : (to ? T + 1 : d + 2);
        ncyc = !legal ? 0 : (to ? T : d + 1);
    endtask

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdv, input int d);
        logic        legal, err_e;
        logic [31:0] rd_e, wd_e;
        logic [3:0]  strb_e;
        int          lat, ncyc;
        bit          got;
        model(we, sz, u, a, wd, rdv, d, legal, rd_e, err_e, strb_e, wd_e, lat, ncyc);
        @(negedge clk);
        ack_delay    = d;
        resp_rdata   = rdv;
        mem_req      = 1'b1;
        mem_we       = we;
        mem_size     = sz;
        mem_unsigned = u;
        addr         = a;
        wdata        = wd;
        dq.push_back('{rd: rd_e, err: err_e, done_cyc: cyc + lat});
        if (legal) bq.push_back('{we: we, addr: {a[31:2], 2'b00}, strb: strb_e, wdata: wd_e, ncyc: ncyc});
        #1 chk("stall_issue", {31'd0, stall}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else chk("stall_busy", {31'd0, stall}, 32'd1);
        end
        if (!got) begin
            nmis++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
            finish_run();
        end
        chk("stall_done", {31'd0, stall}, 32'd0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            mem_req = 1'b0;
            addr    = $urandom;
            wdata   = $urandom;
        end
    endtask

    // Bus responder: acks after ack_delay wait cycles; junk ack outside REQ.
    int rcnt = 0;
    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            bus_ack   = (rcnt == ack_delay) && (ack_delay < T);
            bus_rdata = bus_ack ? resp_rdata : $urandom;
            rcnt++;
        end else begin
            rcnt      = 0;
            bus_ack   = 1'($urandom % 2);
            bus_rdata = $urandom;
        end
    end

    // Completion monitor.
    done_t e;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = dq.pop_front();
                chk("rd", rd, e.rd);
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("done_cycle", cyc, e.done_cyc);
                exp_hold = e.rd;
            end
        end else begin
            chk("err_idle", {31'd0, err}, 32'd0);
            if (rst === 1'b0) chk("rd_hold", rd, exp_hold);
        end
    end

    // Bus monitor: outputs stable and correct for every REQ cycle.
    bus_t b;
    int   brcyc = 0;
    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            if (bq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_bus_req: got bus_req=1 expected 0");
            end else begin
                b = bq[0];
                chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
                chk("bus_addr", bus_addr, b.addr);
                chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, b.strb});
                if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
            end
            brcyc++;
        end else if (brcyc > 0) begin
            if (bq.size() > 0) begin
                b = bq.pop_front();
                chk("req_cycles", brcyc, b.ncyc);
            end
            brcyc = 0;
        end
    end

    initial begin
        #500000;
        nmis++;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        finish_run();
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
        mem_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h1111_2222, 0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 1);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3);
        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h5555_AAAA, 0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h5555_AAAA, 0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h1234_5678, 9);
        do_txn(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, T - 1);
        do_txn(1'b0, 2'd1, 1'b0, 32'h406, 32'h0, 32'h8001_7FFF, 2);

        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom % 4);
            a  = $urandom;
            if (($urandom % 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, $urandom,
                   $urandom_range(0, 5));
        end

        // Reset during the second REQ cycle aborts the access silently.
        @(negedge clk);
        ack_delay = 100;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; addr = 32'h300;
        bq.push_back('{we: 1'b0, addr: 32'h300, strb: 4'b0000, wdata: 32'd0, ncyc: 2});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #1 exp_hold = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bus_req", {31'd0, bus_req}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rd", rd, 32'd0);
        chk("abort_bus_addr", bus_addr, 32'd0);
        chk("abort_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        repeat (2) @(negedge clk);
        do_txn(1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 32'hBEEF_0123, 1);
        @(negedge clk);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_done_empty", dq.size(), 32'd0);
        chk("sb_bus_empty", bq.size(), 32'd0);
        finish_run();
    end

endmodule

`default_nettype wire
